sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 core.
- Accepts an arbitrary-length byte message as a stream of 32-bit big-endian words.
- Assembles 512-bit blocks and applies FIPS 180-4 padding: 0x80 byte, zero fill, 64-bit bit length.
- Issues init/next command pulses plus the block to the core, honouring core ready. Relieves firmware of block formatting and padding for stream sources such as mailbox or DMA.

Parameters:
- DATA_WIDTH, 32, input word width; only 32 is supported.
- BLOCK_WORDS, 16, words per block (512/DATA_WIDTH); fixed.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- zeroize  input  1  synchronous clear of all state and data
- msg_valid  input  1  input word valid
- msg_ready  output  1  padder accepts a word this cycle
- msg_data  input  32  message word; byte 0 in [31:24]
- msg_last  input  1  current word is the final word of the message
- msg_last_bytes  input  2  valid bytes in the final word, left-aligned; 0 encodes 4
- core_ready  input  1  core ready
- core_init  output  1  one-cycle pulse: first block of a message
- core_next  output  1  one-cycle pulse: subsequent block
- core_block  output  512  block to the core; word 0 in [511:480]
- msg_done  output  1  one-cycle pulse after the last block of a message is issued
- busy  output  1  high from the first accepted word until msg_done

Behaviour:
- Reset / zeroize values: all outputs 0, core_block 0, state FILL, word index 0, bit counter 0, first flag 1, pend80 0.
- zeroize has priority over every other event and aborts any in-flight message; no pulse is issued in the zeroize cycle.
- States: FILL, ISSUE, WAIT, PAD.
- FILL: msg_ready = 1.
  - On msg_valid & msg_ready, the word is written to buffer[idx] and the bit counter adds 32, or 8*n for a last word.
  - Non-last word: idx increments; at idx 15 the block is full, go to ISSUE with more = 1.
  - Last word with n < 4 bytes: bytes beyond n are zeroed and byte n is set to 0x80.
  - Last word with n = 4: the word is stored as-is and pend80 = 1.
  - Length-fit rule: let k be the next free word index (k = idx+1). If k <= 14 and the 0x80 is already placed, or pend80 with k <= 13, then place any pending 0x80 at word k, zero the remaining words, write the counter to words 14-15, set final = 1 and go to ISSUE.
  - Otherwise place a pending 0x80 only if k <= 15, zero the remainder, set extra = 1 and go to ISSUE.
- ISSUE: msg_ready = 0 and core_block is driven from the buffer.
  - When core_ready = 1, pulse core_init if first is set, else core_next; then clear first and go to WAIT.
  - core_block is held stable from ISSUE through the end of WAIT.
- WAIT: the first cycle after the pulse is ignored, covering the core's ready deassert latency. Then wait for core_ready = 1.
  - If final: pulse msg_done, set first = 1, clear the counter, go to FILL.
  - Else if extra: go to PAD.
  - Else: set idx = 0 and go to FILL.
- PAD (one cycle): builds the extra block.
  - Word 0 = 0x80000000 if pend80 is still set, else 0.
  - Words 1-13 = 0; words 14-15 = bit counter.
  - Set final = 1, clear pend80, go to ISSUE.
- Bit counter is 64-bit and wraps modulo 2^64.
- A zero-length message is not supported; firmware uses the core directly for it.
- msg_last_bytes is ignored when msg_last = 0.
- Back-to-back messages are allowed; the next message's first word is accepted in the cycle after msg_done.
- Throughput: 16 fill cycles + 1 + core latency per block. Worst-case padding adds exactly one block.

Test Plan:
- "abc" as one word 0x61626300 with last, msg_last_bytes = 3 -> one core_init with block word0 = 0x61626380, words 1-14 = 0, word15 = 0x00000018; msg_done one cycle after core_ready returns.
- 55-byte message (14 words, last n = 3) -> single block, word13 low byte 0x80, words 14-15 = 0x00000000_000001B8.
- 56-byte message (14 full words, last n = 4) -> block 1 word14 = 0x80000000, word15 = 0 via core_init; block 2 words 0-13 = 0, word15 = 0x000001C0 via core_next.
- 64-byte message -> block 1 is pure data; block 2 word0 = 0x80000000, word15 = 0x00000200; exactly one init and one next.
- core_ready held low for 20 cycles in ISSUE -> no pulse, msg_ready = 0, core_block stable; the pulse occurs on the first cycle core_ready = 1.
- zeroize asserted mid-fill (idx = 7) -> the next cycle shows all outputs 0 and busy = 0; a following "abc" message produces the correct single block with core_init.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Message-stream and core-command bundle around the SHA-256 padder.
// The master view belongs to the padder: it drives msg_ready and the core command.
// The slave view is the message source together with the core.
interface sha256_msg_padder_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 16
);
  logic                              msg_valid;
  logic                              msg_ready;
  logic [DATA_WIDTH-1:0]             msg_data;
  logic                              msg_last;
  logic [1:0]                        msg_last_bytes;
  logic                              core_ready;
  logic                              core_init;
  logic                              core_next;
  logic [DATA_WIDTH*BLOCK_WORDS-1:0] core_block;

  modport master (
    input  msg_valid, msg_data, msg_last, msg_last_bytes, core_ready,
    output msg_ready, core_init, core_next, core_block
  );

  modport slave (
    output msg_valid, msg_data, msg_last, msg_last_bytes, core_ready,
    input  msg_ready, core_init, core_next, core_block
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Packs 32-bit big-endian words into 512-bit blocks, appends the FIPS 180-4
// 0x80 / zero fill / 64-bit length trailer, and issues init/next to the core.
module sha256_msg_padder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                zeroize,
  sha256_msg_padder_if.master bus,
  output logic                msg_done,
  output logic                busy
);
  localparam int unsigned BLOCK_BITS = DATA_WIDTH * BLOCK_WORDS;
  localparam int unsigned IDX_W      = $clog2(BLOCK_WORDS);
  localparam int unsigned K_W        = IDX_W + 1;

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, PAD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [63:0]             bitcnt_q, bitcnt_d;
  logic                    first_q, first_d;
  logic                    pend80_q, pend80_d;
  logic                    final_q, final_d;
  logic                    extra_q, extra_d;
  logic                    skip_q, skip_d;
  logic [DATA_WIDTH-1:0]   buf_q [BLOCK_WORDS];
  logic [DATA_WIDTH-1:0]   buf_d [BLOCK_WORDS];
  logic [BLOCK_BITS-1:0]   core_block_q, core_block_d;
  logic                    core_init_q, core_init_d;
  logic                    core_next_q, core_next_d;
  logic                    msg_done_q, msg_done_d;
  logic                    busy_q, busy_d;
  logic                    msg_ready_q, msg_ready_d;

  logic [2:0]              nbytes;
  logic [DATA_WIDTH-1:0]   word;
  logic [K_W-1:0]          k;
  logic                    pend_now;
  logic                    fits;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      idx_q        <= '0;
      bitcnt_q     <= '0;
      first_q      <= 1'b1;
      pend80_q     <= 1'b0;
      final_q      <= 1'b0;
      extra_q      <= 1'b0;
      skip_q       <= 1'b0;
      for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_q[i] <= '0;
      core_block_q <= '0;
      core_init_q  <= 1'b0;
      core_next_q  <= 1'b0;
      msg_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      msg_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bitcnt_q     <= bitcnt_d;
      first_q      <= first_d;
      pend80_q     <= pend80_d;
      final_q      <= final_d;
      extra_q      <= extra_d;
      skip_q       <= skip_d;
      for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_q[i] <= buf_d[i];
      core_block_q <= core_block_d;
      core_init_q  <= core_init_d;
      core_next_q  <= core_next_d;
      msg_done_q   <= msg_done_d;
      busy_q       <= busy_d;
      msg_ready_q  <= msg_ready_d;
    end
  end

  // Next-state, buffer assembly/padding and output decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bitcnt_d     = bitcnt_q;
    first_d      = first_q;
    pend80_d     = pend80_q;
    final_d      = final_q;
    extra_d      = extra_q;
    skip_d       = skip_q;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_d[i] = buf_q[i];
    core_block_d = core_block_q;
    core_init_d  = 1'b0;
    core_next_d  = 1'b0;
    msg_done_d   = 1'b0;
    busy_d       = busy_q;
    msg_ready_d  = 1'b0;
    nbytes       = 3'd4;
    word         = '0;
    k            = '0;
    pend_now     = 1'b0;
    fits         = 1'b0;

    if (zeroize) begin
      state_d      = FILL;
      idx_d        = '0;
      bitcnt_d     = '0;
      first_d      = 1'b1;
      pend80_d     = 1'b0;
      final_d      = 1'b0;
      extra_d      = 1'b0;
      skip_d       = 1'b0;
      busy_d       = 1'b0;
      core_block_d = '0;
      for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_d[i] = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.msg_valid && msg_ready_q) begin
            busy_d = 1'b1;
            if (bus.msg_last && (bus.msg_last_bytes != 2'd0)) nbytes = {1'b0, bus.msg_last_bytes};
            bitcnt_d = bitcnt_q + (64'(nbytes) << 3);
            if (!bus.msg_last) begin
              buf_d[idx_q] = bus.msg_data;
              idx_d        = idx_q + IDX_W'(1);
              if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
                idx_d   = '0;
                state_d = ISSUE;
              end
            end else begin
              // Short final word: drop trailing junk and place the 0x80 right after it.
              unique case (bus.msg_last_bytes)
                2'd1:    word = {bus.msg_data[31:24], 8'h80, 16'h0000};
                2'd2:    word = {bus.msg_data[31:16], 8'h80, 8'h00};
                2'd3:    word = {bus.msg_data[31:8], 8'h80};
                default: word = bus.msg_data;
              endcase
              pend_now = (bus.msg_last_bytes == 2'd0);
              k        = K_W'(idx_q) + K_W'(1);
              fits     = pend_now ? (k <= K_W'(BLOCK_WORDS - 3)) : (k <= K_W'(BLOCK_WORDS - 2));
              for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
                if (i > int'(idx_q)) buf_d[i] = '0;
              end
              buf_d[idx_q] = word;
              if (pend_now && (k <= K_W'(BLOCK_WORDS - 1))) buf_d[k[IDX_W-1:0]] = 32'h8000_0000;
              pend80_d = pend_now && (k > K_W'(BLOCK_WORDS - 1));
              if (fits) begin
                buf_d[BLOCK_WORDS-2] = bitcnt_d[63:32];
                buf_d[BLOCK_WORDS-1] = bitcnt_d[31:0];
                final_d              = 1'b1;
              end else begin
                extra_d = 1'b1;
              end
              idx_d   = '0;
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.core_ready) begin
            core_init_d = first_q;
            core_next_d = !first_q;
            first_d     = 1'b0;
            skip_d      = 1'b1;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          // The pulse cycle is skipped: the core's ready may not have dropped yet.
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (bus.core_ready) begin
            if (final_q) begin
              msg_done_d = 1'b1;
              busy_d     = 1'b0;
              first_d    = 1'b1;
              bitcnt_d   = '0;
              final_d    = 1'b0;
              idx_d      = '0;
              state_d    = FILL;
            end else if (extra_q) begin
              extra_d = 1'b0;
              state_d = PAD;
            end else begin
              idx_d   = '0;
              state_d = FILL;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_d[i] = '0;
          buf_d[0]             = pend80_q ? 32'h8000_0000 : 32'h0000_0000;
          buf_d[BLOCK_WORDS-2] = bitcnt_q[63:32];
          buf_d[BLOCK_WORDS-1] = bitcnt_q[31:0];
          final_d              = 1'b1;
          pend80_d             = 1'b0;
          state_d              = ISSUE;
        end
        default: state_d = FILL;
      endcase

      // Block presented to the core is frozen while issuing and waiting.
      if (state_d == ISSUE) begin
        for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
          core_block_d[(BLOCK_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH] = buf_d[i];
        end
      end
      msg_ready_d = (state_d == FILL);
    end
  end

  assign bus.msg_ready  = msg_ready_q;
  assign bus.core_init  = core_init_q;
  assign bus.core_next  = core_next_q;
  assign bus.core_block = core_block_q;
  assign msg_done       = msg_done_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random and directed messages against a byte-level
// FIPS 180-4 padding model, with a simple core that drops ready after each command.
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic reset_n;
  logic zeroize;
  logic msg_done;
  logic busy;

  int total = 0;
  int bad   = 0;

  sha256_msg_padder_if ifc ();

  sha256_msg_padder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .zeroize  (zeroize),
    .bus      (ifc.master),
    .msg_done (msg_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [511:0]  got_blk [$];
  logic [1:0]    got_cmd [$];
  logic [511:0]  exp_blk [$];
  logic [1:0]    exp_cmd [$];
  byte unsigned  msg_q [$];
  int            done_cnt  = 0;
  int            lat_cnt   = 0;
  int            core_lat  = 0;
  bit            core_hold = 1'b0;
  int            target    = 0;
  int            lens [13] = '{1, 4, 52, 55, 56, 59, 60, 63, 64, 65, 119, 120, 128};

  // Core model: captures each command, drops ready for core_lat cycles afterwards.
  always @(negedge clk) begin
    if (ifc.core_init || ifc.core_next) begin
      got_blk.push_back(ifc.core_block);
      got_cmd.push_back({ifc.core_init, ifc.core_next});
      lat_cnt = core_lat;
      ifc.core_ready = 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
    end else begin
      ifc.core_ready = !core_hold;
    end
    if (msg_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: FIPS 180-4 padding on the byte string, then cut into 64-byte blocks.
  task automatic build_expected();
    byte unsigned p [$];
    logic [63:0]  len;
    logic [511:0] blk;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    len = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk = {blk[503:0], p[64*b+j]};
      exp_blk.push_back(blk);
      exp_cmd.push_back((b == 0) ? 2'b10 : 2'b01);
    end
  endtask

  task automatic make_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] lb);
    int n;
    n = 0;
    ifc.msg_valid      = 1'b1;
    ifc.msg_data       = d;
    ifc.msg_last       = last;
    ifc.msg_last_bytes = lb;
    while (ifc.msg_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("word_accept_in_time", 512'(n < 1000), 512'(1));
    step();
    ifc.msg_valid = 1'b0;
  endtask

  // Sends msg_q; bytes past the end of the final word and lb of non-last words are junk.
  task automatic send_msg();
    int sz;
    int nw;
    int nb;
    logic [31:0] d;
    logic [7:0]  by;
    build_expected();
    sz = msg_q.size();
    nw = (sz + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      nb = sz - 4 * w;
      if (nb > 4) nb = 4;
      d = '0;
      for (int b = 0; b < 4; b++) begin
        by = (b < nb) ? msg_q[4*w+b] : 8'($urandom);
        d  = {d[23:0], by};
      end
      if (w == nw - 1) send_word(d, 1'b1, 2'(sz % 4));
      else             send_word(d, 1'b0, 2'($urandom));
    end
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt && n < 3000) begin
      step();
      n++;
    end
    chk("msg_done_seen", 512'(done_cnt >= tgt), 512'(1));
  endtask

  task automatic drain();
    chk("block_count", 512'(got_blk.size()), 512'(exp_blk.size()));
    while (got_blk.size() > 0 && exp_blk.size() > 0) begin
      chk("cmd_init_next", 512'(got_cmd.pop_front()), 512'(exp_cmd.pop_front()));
      chk("block_data", got_blk.pop_front(), exp_blk.pop_front());
    end
    got_blk.delete();
    got_cmd.delete();
    exp_blk.delete();
    exp_cmd.delete();
  endtask

  initial begin
    reset_n            = 1'b0;
    zeroize            = 1'b0;
    ifc.msg_valid      = 1'b0;
    ifc.msg_data       = '0;
    ifc.msg_last       = 1'b0;
    ifc.msg_last_bytes = '0;
    repeat (3) step();

    // Reset values.
    chk("rst_msg_ready", 512'(ifc.msg_ready), 512'(0));
    chk("rst_core_init", 512'(ifc.core_init), 512'(0));
    chk("rst_core_next", 512'(ifc.core_next), 512'(0));
    chk("rst_msg_done", 512'(msg_done), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_core_block", ifc.core_block, 512'(0));
    reset_n = 1'b1;
    step();
    step();
    chk("ready_after_reset", 512'(ifc.msg_ready), 512'(1));

    // "abc" in one word.
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    send_msg();
    chk("busy_during_msg", 512'(busy), 512'(1));
    target++;
    wait_done(target);
    chk("busy_after_done", 512'(busy), 512'(0));
    chk("abc_word0", 512'(got_blk[0][511:480]), 512'(32'h6162_6380));
    chk("abc_word15", 512'(got_blk[0][31:0]), 512'(32'h0000_0018));
    drain();

    // Length boundaries around the 55/56/64-byte padding limits.
    foreach (lens[i]) begin
      core_lat = $urandom_range(0, 4);
      make_msg(lens[i]);
      send_msg();
      target++;
      wait_done(target);
      drain();
    end

    // Core not ready for 20 cycles while a block is pending.
    core_hold = 1'b1;
    repeat (10) step();
    make_msg(20);
    send_msg();
    for (int c = 0; c < 20; c++) begin
      chk("stall_no_pulse", 512'({ifc.core_init, ifc.core_next}), 512'(0));
      chk("stall_msg_ready", 512'(ifc.msg_ready), 512'(0));
      chk("stall_block", ifc.core_block, exp_blk[0]);
      step();
    end
    core_hold = 1'b0;
    for (int n = 0; n < 10 && ifc.core_ready !== 1'b1; n++) step();
    step();
    chk("pulse_on_ready", 512'(ifc.core_init), 512'(1));
    target++;
    wait_done(target);
    drain();

    // Back-to-back messages.
    core_lat = 1;
    make_msg(10);
    send_msg();
    make_msg(70);
    send_msg();
    target += 2;
    wait_done(target);
    drain();

    // Random lengths and core latencies.
    for (int t = 0; t < 10; t++) begin
      core_lat = $urandom_range(0, 5);
      make_msg($urandom_range(1, 150));
      send_msg();
      target++;
      wait_done(target);
      drain();
    end

    // Zeroize after 7 words of a message, then a clean "abc".
    for (int w = 0; w < 7; w++) send_word($urandom, 1'b0, 2'($urandom));
    zeroize = 1'b1;
    step();
    chk("zero_msg_ready", 512'(ifc.msg_ready), 512'(0));
    chk("zero_busy", 512'(busy), 512'(0));
    chk("zero_pulses", 512'({ifc.core_init, ifc.core_next, msg_done}), 512'(0));
    chk("zero_core_block", ifc.core_block, 512'(0));
    zeroize = 1'b0;
    step();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    send_msg();
    target++;
    wait_done(target);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
